// File: rtl/brainhack_pkg.sv
// Shared opcode, state and width definitions for the BrainHack data-tape path.
package brainhack_pkg;

    localparam int c_default_addr_width = 8;
    localparam int c_default_data_width = 8;
    localparam int c_default_arg_width  = 8;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_ADD    = 4'd1,
        OP_SUB    = 4'd2,
        OP_RIGHT  = 4'd3,
        OP_LEFT   = 4'd4,
        OP_IN     = 4'd5,
        OP_OUT    = 4'd6,
        OP_CLR    = 4'd7,
        OP_SCAN_R = 4'd8,
        OP_SCAN_L = 4'd9
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

endpackage

// File: rtl/tape_ptr_step.sv
// Combinational data-pointer step shared by RIGHT/LEFT and scans.
// TAPE_BOUND_CHECK_EN selects clamping at the tape ends instead of wrapping.
module tape_ptr_step #(
    parameter int c_addr_width = 8,
    parameter int c_arg_width  = 8
) (
    input  logic [c_addr_width-1:0] i_ptr,
    input  logic [c_arg_width-1:0]  i_stride,
    input  logic                    i_left,
    output logic [c_addr_width-1:0] o_ptr,
    output logic                    o_saturated
);

`ifdef TAPE_BOUND_CHECK_EN
    // One spare bit so the true sum/difference is visible before clamping.
    localparam int c_wide = ((c_addr_width > c_arg_width) ? c_addr_width : c_arg_width) + 1;
    localparam logic [c_wide-1:0] c_last = {{(c_wide - c_addr_width){1'b0}}, {c_addr_width{1'b1}}};

    logic [c_wide-1:0] ptr_wide;
    logic [c_wide-1:0] stride_wide;
    logic [c_wide-1:0] sum_wide;

    always_comb begin
        ptr_wide    = c_wide'(i_ptr);
        stride_wide = c_wide'(i_stride);
        sum_wide    = ptr_wide + stride_wide;
        o_saturated = 1'b0;
        o_ptr       = i_ptr;
        if (i_left) begin
            if (stride_wide > ptr_wide) begin
                o_ptr       = '0;
                o_saturated = 1'b1;
            end else begin
                o_ptr = c_addr_width'(ptr_wide - stride_wide);
            end
        end else begin
            if (sum_wide > c_last) begin
                o_ptr       = '1;
                o_saturated = 1'b1;
            end else begin
                o_ptr = c_addr_width'(sum_wide);
            end
        end
    end
`else
    logic [c_addr_width-1:0] stride_addr;

    assign stride_addr = c_addr_width'(i_stride);
    assign o_ptr       = i_left ? (i_ptr - stride_addr) : (i_ptr + stride_addr);
    assign o_saturated = 1'b0;
`endif

endmodule

// File: rtl/tape_controller.sv
// Data-tape execution unit: owns the data pointer, does read-modify-write on the
// current cell and multi-cycle scans. Optional TAPE_BOUND_CHECK_EN clamps the pointer.
module tape_controller
    import brainhack_pkg::*;
#(
    parameter int c_addr_width = c_default_addr_width,
    parameter int c_data_width = c_default_data_width,
    parameter int c_arg_width  = c_default_arg_width
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [3:0]              i_cmd_op,
    input  logic [c_arg_width-1:0]  i_cmd_arg,
    output logic                    o_done,
    output logic                    o_zero,
    output logic                    o_out_valid,
    output logic [c_data_width-1:0] o_out_data,
    output logic                    o_error,
    output logic [c_addr_width-1:0] o_ptr,
    output logic [c_addr_width-1:0] o_ram_addr,
    output logic [c_data_width-1:0] o_ram_data,
    output logic                    o_ram_enable_in,
    input  logic [c_data_width-1:0] i_ram_data,
    output state_t                  o_state
);

    localparam logic [c_addr_width:0] c_scan_limit = {1'b1, {c_addr_width{1'b0}}};

    state_t                  state;
    logic [c_addr_width-1:0] ptr;
    logic [3:0]              op_q;
    logic [c_arg_width-1:0]  arg_q;
    logic [c_addr_width:0]   step_cnt;
    logic [c_addr_width:0]   step_cnt_next;
    logic                    done_q;
    logic                    out_valid_q;
    logic [c_data_width-1:0] out_data_q;
    logic                    error_q;

    logic                    cell_zero;
    logic                    scan_op;
    logic                    step_left;
    logic [c_arg_width-1:0]  stride;
    logic [c_addr_width-1:0] step_ptr;
    logic                    step_sat;
    logic [c_data_width-1:0] arg_data;
    logic [c_data_width-1:0] ram_wdata;
    logic                    ram_we;

    assign cell_zero     = (i_ram_data == '0);
    assign scan_op       = (op_q == OP_SCAN_R) || (op_q == OP_SCAN_L);
    assign step_left     = (op_q == OP_LEFT) || (op_q == OP_SCAN_L);
    assign stride        = (scan_op && (arg_q == '0)) ? c_arg_width'(1) : arg_q;
    assign arg_data      = c_data_width'(arg_q);
    assign step_cnt_next = step_cnt + 1'b1;

    tape_ptr_step #(
        .c_addr_width (c_addr_width),
        .c_arg_width  (c_arg_width)
    ) u_ptr_step (
        .i_ptr       (ptr),
        .i_stride    (stride),
        .i_left      (step_left),
        .o_ptr       (step_ptr),
        .o_saturated (step_sat)
    );

    // Cell ALU: the write happens only during the single EXEC cycle.
    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (state == ST_EXEC) begin
            case (op_q)
                OP_ADD: begin ram_we = 1'b1; ram_wdata = i_ram_data + arg_data; end
                OP_SUB: begin ram_we = 1'b1; ram_wdata = i_ram_data - arg_data; end
                OP_IN:  begin ram_we = 1'b1; ram_wdata = arg_data;              end
                OP_CLR: begin ram_we = 1'b1; ram_wdata = '0;                    end
                default: ;
            endcase
        end
    end

    // Command handshake: a command transfers on a rising edge where i_cmd_valid and
    // o_cmd_ready are both high; the sequencer holds valid and payload until then.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            op_q        <= OP_NOP;
            arg_q       <= '0;
            step_cnt    <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        op_q  <= i_cmd_op;
                        arg_q <= i_cmd_arg;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b1;
                    case (op_q)
                        OP_RIGHT, OP_LEFT: begin
                            ptr <= step_ptr;
                            if (step_sat) error_q <= 1'b1;
                        end
                        OP_OUT: begin
                            out_data_q  <= i_ram_data;
                            out_valid_q <= 1'b1;
                        end
                        OP_SCAN_R, OP_SCAN_L: begin
                            if (!cell_zero) begin
                                ptr      <= step_ptr;
                                step_cnt <= '0;
                                if (step_sat) begin
                                    error_q <= 1'b1;
                                end else begin
                                    state  <= ST_SCAN;
                                    done_q <= 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
                ST_SCAN: begin
                    if (cell_zero) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        ptr      <= step_ptr;
                        step_cnt <= step_cnt_next;
                        // A full lap without a zero cell, or hitting a tape end, aborts the scan.
                        if (step_sat || (step_cnt_next == c_scan_limit)) begin
                            error_q <= 1'b1;
                            state   <= ST_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready     = (state == ST_IDLE) && !i_reset;
    assign o_done          = done_q;
    assign o_zero          = cell_zero;
    assign o_out_valid     = out_valid_q;
    assign o_out_data      = out_data_q;
    assign o_error         = error_q;
    assign o_ptr           = ptr;
    assign o_ram_addr      = ptr;
    assign o_ram_data      = ram_wdata;
    assign o_ram_enable_in = ram_we;
    assign o_state         = state;

endmodule

// File: tb/tb_tape_controller.sv
// Scoreboard bench for tape_controller with a behavioural tape RAM.
module tb_tape_controller;
    import brainhack_pkg::*;

    localparam int c_exp_w = 31;

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_op = 4'd0;
    logic [7:0] cmd_arg = 8'd0;
    logic       o_cmd_ready, o_done, o_zero, o_out_valid, o_error, o_ram_enable_in;
    logic [7:0] o_out_data, o_ptr, o_ram_addr, o_ram_data, ram_rdata;
    state_t     dbg_state;

    logic [7:0] ram_mem [256];
    logic       fill_req = 1'b1;
    logic [7:0] fill_val = 8'h00;

    logic [c_exp_w-1:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         wr_cnt = 0;
    logic       err_exp = 1'b0;
    logic [7:0] od_exp = 8'h00;

    tape_controller dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_op        (cmd_op),
        .i_cmd_arg       (cmd_arg),
        .o_done          (o_done),
        .o_zero          (o_zero),
        .o_out_valid     (o_out_valid),
        .o_out_data      (o_out_data),
        .o_error         (o_error),
        .o_ptr           (o_ptr),
        .o_ram_addr      (o_ram_addr),
        .o_ram_data      (o_ram_data),
        .o_ram_enable_in (o_ram_enable_in),
        .i_ram_data      (ram_rdata),
        .o_state         (dbg_state)
    );

    // Clock and tape RAM (asynchronous read, synchronous write, bulk fill).
    always #5 i_clock = ~i_clock;

    assign ram_rdata = ram_mem[o_ram_addr];

    always @(posedge i_clock) begin
        if (fill_req) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= fill_val;
        end else if (o_ram_enable_in) begin
            ram_mem[o_ram_addr] <= o_ram_data;
        end
    end

    // Edge bookkeeping: values read here are the pre-edge ones.
    always @(posedge i_clock) begin
        if (o_ram_enable_in) wr_cnt = wr_cnt + 1;
        if (cmd_valid && o_cmd_ready) begin
            acc_cyc = cyc;
            wr_cnt  = 0;
        end
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [c_exp_w-1:0] mk(input int lat, input int wr, input logic [7:0] ptr,
                                              input logic zero, input logic err, input logic ov,
                                              input logic [7:0] od);
        return {10'(lat), 2'(wr), ptr, zero, err, ov, od};
    endfunction

    // Monitor: every done pulse pops one expected response.
    always @(negedge i_clock) begin
        logic [c_exp_w-1:0] act;
        logic [c_exp_w-1:0] exp;
        if (!i_reset) begin
            if (o_out_valid && !o_done) check("out_valid_without_done", 32'(o_out_valid), 32'd0);
            if (o_done) begin
                act = {10'(cyc - acc_cyc), 2'(wr_cnt), o_ptr, o_zero, o_error, o_out_valid, o_out_data};
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(act), 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("done_resp{lat,wr,ptr,zero,err,ov,od}", 32'(act), 32'(exp));
                end
            end
        end
    end

    // Driver: waits for ready, presents one command for one accepting edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] arg, input bit push,
                         input int lat, input int wr, input logic [7:0] ptr,
                         input logic zero, input logic ov);
        int t = 0;
        @(negedge i_clock);
        while (!o_cmd_ready && t < 600) begin
            @(negedge i_clock);
            t++;
        end
        if (t >= 600) check("cmd_ready_timeout", 32'(o_cmd_ready), 32'd1);
        if (push) exp_q.push_back(mk(lat, wr, ptr, zero, err_exp, ov, od_exp));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge i_clock);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || !o_cmd_ready) && t < 600) begin
            @(negedge i_clock);
            t++;
        end
        if (t >= 600) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge i_clock);
        i_reset = 1'b1;
        repeat (n) @(negedge i_clock);
        i_reset = 1'b0;
        err_exp = 1'b0;
        od_exp  = 8'h00;
        #1;
        check("rst_ptr", 32'(o_ptr), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_ready", 32'(o_cmd_ready), 32'd1);
        check("rst_out_valid", 32'(o_out_valid), 32'd0);
        check("rst_out_data", 32'(o_out_data), 32'd0);
        check("rst_ram_we", 32'(o_ram_enable_in), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge i_clock);
        fill_req = 1'b0;
        pulse_reset(1);
        check("rst_zero_on_blank_tape", 32'(o_zero), 32'd1);

        // ADD twice, RIGHT, SUB wrap, CLR, LEFT back and past cell 0.
        issue(OP_ADD,   8'd3, 1, 2, 1, 8'd0, 1'b0, 1'b0);
        issue(OP_ADD,   8'd3, 1, 2, 1, 8'd0, 1'b0, 1'b0);
        drain();
        check("cell0_after_adds", 32'(ram_mem[0]), 32'h06);
        issue(OP_RIGHT, 8'd1, 1, 2, 0, 8'd1, 1'b1, 1'b0);
        issue(OP_SUB,   8'd1, 1, 2, 1, 8'd1, 1'b0, 1'b0);
        drain();
        check("cell1_sub_wrap", 32'(ram_mem[1]), 32'hFF);
        issue(OP_CLR,   8'd9, 1, 2, 1, 8'd1, 1'b1, 1'b0);
        issue(OP_LEFT,  8'd1, 1, 2, 0, 8'd0, 1'b0, 1'b0);
`ifdef TAPE_BOUND_CHECK_EN
        err_exp = 1'b1;
        issue(OP_LEFT,  8'd1, 1, 2, 0, 8'd0, 1'b0, 1'b0);
`else
        issue(OP_LEFT,  8'd1, 1, 2, 0, 8'd255, 1'b1, 1'b0);
`endif
        drain();
        check("cell1_after_clr", 32'(ram_mem[1]), 32'h00);
        pulse_reset(2);

        // Build cells 5,6,7 nonzero with cell 8 zero, then scan right.
        issue(OP_RIGHT,  8'd5, 1, 2, 0, 8'd5, 1'b1, 1'b0);
        issue(OP_IN,     8'd1, 1, 2, 1, 8'd5, 1'b0, 1'b0);
        issue(OP_RIGHT,  8'd1, 1, 2, 0, 8'd6, 1'b1, 1'b0);
        issue(OP_IN,     8'd2, 1, 2, 1, 8'd6, 1'b0, 1'b0);
        issue(OP_RIGHT,  8'd1, 1, 2, 0, 8'd7, 1'b1, 1'b0);
        issue(OP_IN,     8'd3, 1, 2, 1, 8'd7, 1'b0, 1'b0);
        issue(OP_LEFT,   8'd2, 1, 2, 0, 8'd5, 1'b0, 1'b0);
        issue(OP_SCAN_R, 8'd1, 1, 5, 0, 8'd8, 1'b1, 1'b0);
        issue(OP_SCAN_R, 8'd1, 1, 2, 0, 8'd8, 1'b1, 1'b0);
        issue(OP_LEFT,   8'd3, 1, 2, 0, 8'd5, 1'b0, 1'b0);
        issue(OP_SCAN_R, 8'd0, 1, 5, 0, 8'd8, 1'b1, 1'b0);
        drain();

        // Every cell nonzero: scan left cannot find a zero.
        @(negedge i_clock);
        fill_val = 8'h11;
        fill_req = 1'b1;
        @(negedge i_clock);
        fill_req = 1'b0;
        err_exp  = 1'b1;
`ifdef TAPE_BOUND_CHECK_EN
        issue(OP_SCAN_L, 8'd1, 1, 10, 0, 8'd0, 1'b0, 1'b0);
`else
        issue(OP_SCAN_L, 8'd1, 1, 258, 0, 8'd7, 1'b0, 1'b0);
`endif
        drain();
        check("error_sticky_in_idle", 32'(o_error), 32'd1);
        check("scan_left_tape_intact", 32'(ram_mem[7]), 32'h11);

        // Reset in the middle of a long scan.
        issue(OP_SCAN_R, 8'd1, 0, 0, 0, 8'd0, 1'b0, 1'b0);
        repeat (20) @(negedge i_clock);
        pulse_reset(1);
        check("reset_keeps_tape", 32'(ram_mem[0]), 32'h11);

        // IN/OUT, NOPs, ALU wrap, CLR, zero-length move.
        issue(OP_IN,    8'h41, 1, 2, 1, 8'd0, 1'b0, 1'b0);
        od_exp = 8'h41;
        issue(OP_OUT,   8'h00, 1, 2, 0, 8'd0, 1'b0, 1'b1);
        issue(OP_NOP,   8'h07, 1, 2, 0, 8'd0, 1'b0, 1'b0);
        issue(4'd12,    8'h07, 1, 2, 0, 8'd0, 1'b0, 1'b0);
        drain();
        check("cell0_after_nops", 32'(ram_mem[0]), 32'h41);
        issue(OP_ADD,   8'hC0, 1, 2, 1, 8'd0, 1'b0, 1'b0);
        drain();
        check("cell0_add_wrap", 32'(ram_mem[0]), 32'h01);
        issue(OP_SUB,   8'h02, 1, 2, 1, 8'd0, 1'b0, 1'b0);
        drain();
        check("cell0_sub_wrap", 32'(ram_mem[0]), 32'hFF);
        issue(OP_CLR,   8'h00, 1, 2, 1, 8'd0, 1'b1, 1'b0);
        issue(OP_RIGHT, 8'h00, 1, 2, 0, 8'd0, 1'b1, 1'b0);
        drain();
        check("out_data_held", 32'(o_out_data), 32'h41);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tape_controller.md
Name: tape_controller

Overview:
- Data-tape execution unit of the BrainHack core; sits directly upstream of the tape RAM and is its only master.
- Owns the data pointer and accepts decoded, run-length-compressed data commands from the instruction sequencer.
- Performs read-modify-write on the current cell and multi-cycle pointer scans.
- Reports the cell-zero flag and output bytes back to the sequencer.

Parameters:
- c_addr_width, 8, tape address width; tape holds 2**c_addr_width cells.
- c_data_width, 8, cell width.
- c_arg_width, 8, command argument width (repeat count or input byte).

Ports:
- i_clock  in  1  single system clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  controller can accept a command.
- i_cmd_op  in  4  opcode, encodings listed under Behaviour.
- i_cmd_arg  in  c_arg_width  repeat count, or the byte for IN.
- o_done  out  1  one-cycle pulse when an accepted command completes.
- o_zero  out  1  current cell == 0, combinational from i_ram_data.
- o_out_valid  out  1  one-cycle pulse carrying an OUT byte.
- o_out_data  out  c_data_width  OUT byte, held until the next OUT.
- o_error  out  1  sticky scan-timeout flag.
- o_ptr  out  c_addr_width  current data pointer.
- o_ram_addr  out  c_addr_width  RAM address; always equals the pointer.
- o_ram_data  out  c_data_width  RAM write data.
- o_ram_enable_in  out  1  RAM write enable.
- i_ram_data  in  c_data_width  RAM asynchronous read data for o_ram_addr.

Behaviour:
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 RIGHT, 4 LEFT, 5 IN, 6 OUT, 7 CLR, 8 SCAN_R, 9 SCAN_L. Opcodes 10-15 are treated as NOP.
- States: IDLE, EXEC, SCAN.
- Reset, synchronous, takes effect at any state including mid-scan:
  - state=IDLE, ptr=0.
  - o_done=0, o_out_valid=0, o_out_data=0, o_error=0, o_ram_enable_in=0.
  - RAM contents are not touched.
- o_cmd_ready=1 only in IDLE and not in reset. On valid&ready, latch op and arg, then go to EXEC.
- EXEC lasts exactly one cycle. Per op:
  - ADD: o_ram_enable_in=1, o_ram_data = i_ram_data + arg, mod 2**c_data_width (arg zero-extended or truncated).
  - SUB: same as ADD with subtraction. Wraps: 0 - 1 = all ones.
  - IN: write arg truncated to c_data_width.
  - CLR: write 0.
  - RIGHT/LEFT: ptr +/- arg, mod 2**c_addr_width. No RAM write.
  - OUT: o_out_data <= i_ram_data; o_out_valid pulses in the following cycle, together with o_done.
  - NOP: no effect; o_done still pulses.
  - All ops except SCAN_x go to IDLE. o_done is registered and pulses in the cycle after EXEC.
  - Single-cycle op latency is therefore: accept edge -> EXEC -> done, 2 cycles. Back-to-back throughput is 1 command per 2 cycles.
- SCAN_R/SCAN_L (arg = stride; stride 0 treated as 1):
  - In EXEC: if cell==0, finish immediately (done pulse, ptr unchanged). Otherwise ptr += / -= stride, clear step counter, go to SCAN.
  - In SCAN, each cycle: if cell==0, go to IDLE with done pulse. Else advance ptr by stride and increment the step counter.
  - If the counter reaches 2**c_addr_width with no zero found: o_error<=1, go to IDLE, pulse done, ptr left where it stopped.
- o_ram_enable_in is high only in EXEC for ADD/SUB/IN/CLR. It is never high in IDLE or SCAN.
- o_zero is valid in every cycle and reflects the cell under the current ptr.
- Commands presented while ready=0 are ignored; the sequencer holds valid until accepted.

Optional Feature:
- Macro TAPE_BOUND_CHECK_EN.
- When defined, RIGHT/LEFT/SCAN never wrap:
  - A move past the last cell saturates at 2**c_addr_width-1; a move below 0 saturates at 0.
  - Either saturation sets o_error (sticky).
  - A saturating scan terminates at that step with done.
- When undefined, all pointer arithmetic wraps modulo 2**c_addr_width and only scan timeout sets o_error.

Decomposition:
- Shared package brainhack_pkg holds:
  - Opcode localparams/enum (OP_NOP ... OP_SCAN_L, 4 bits).
  - Controller state enum (ST_IDLE, ST_EXEC, ST_SCAN).
  - Default widths.
- One natural sub-module: tape_ptr_step, a combinational pointer adder/subtractor handling wrap vs saturate. It is shared by RIGHT/LEFT and SCAN.
- The FSM, op latches, and cell ALU stay in tape_controller.

Test Plan:
- Reset, then ADD arg=3 twice -> cell[0]=6, o_done after each accept at +2 cycles, o_zero=0, ptr=0.
- SUB arg=1 on cell=0 -> cell=8'hFF. Then CLR -> cell=0, o_zero=1.
- LEFT arg=1 from ptr=0 -> ptr=255 without macro. With TAPE_BOUND_CHECK_EN -> ptr=0, o_error=1.
- Cells 5,6,7 nonzero and cell 8=0, ptr=5, SCAN_R stride 1 -> ptr=8, done 4 cycles after EXEC, no RAM writes during scan.
- All cells nonzero, SCAN_L stride 1 -> o_error=1 after 256 scan steps and done pulses. Then assert i_reset mid-next-scan -> IDLE, ptr=0, o_error=0.
- IN arg=8'h41, then OUT -> o_out_valid pulse with o_out_data=8'h41. NOP -> done only, tape unchanged.
